kamikaze_ahb_ram: RTL and testbench

KAMIKAZE_AHB_RAM -- requirements
Module: kamikaze_ahb_ram

---
 rtl/kamikaze_ahb_ram.sv | 160 ++++++++++++++++
 tb/tb_kamikaze_ahb_ram.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kamikaze_ahb_ram.sv
// AHB-Lite RAM slave: 2^ADDR_WIDTH x 32-bit words, optional wait states,
// two-cycle ERROR response for misaligned, oversized or out-of-range transfers.
module kamikaze_ahb_ram #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADYIN,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [1:0] WAIT_INIT = 2'(WAIT_STATES);

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  take;
    logic                  legal;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] ap_word;
    logic [31:0]           rd_merged;

    logic                  dp_active_q;
    logic                  dp_write_q;
    logic [ADDR_WIDTH-1:0] dp_word_q;
    logic [3:0]            dp_be_q;

    logic [31:0]           mem [DEPTH];

    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK};

    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
        case (size)
            3'b000:  return 4'b0001 << off;
            3'b001:  return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    assign ap_word = HADDR[ADDR_WIDTH+1:2];
    assign wr_en   = dp_active_q & dp_write_q & HREADYOUT;

    always_comb begin
        legal = 1'b1;
        if (HSIZE > 3'b010)                          legal = 1'b0;
        if (HSIZE == 3'b001 && HADDR[0])             legal = 1'b0;
        if (HSIZE == 3'b010 && HADDR[1:0] != 2'b00)  legal = 1'b0;
        if ((HADDR >> (ADDR_WIDTH + 2)) != 32'd0)    legal = 1'b0;
    end

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state_q)
            ST_WAIT: HREADYOUT = (cnt_q == 2'd0);
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2: HRESP = 1'b1;
            default: ;
        endcase

        take = HSEL & HTRANS[1] & HREADYIN & HREADYOUT;

        if (take) begin
            if (!legal) begin
                state_d = ST_ERR1;
                cnt_d   = 2'd0;
            end else if (WAIT_STATES == 0) begin
                state_d = ST_IDLE;
                cnt_d   = 2'd0;
            end else begin
                state_d = ST_WAIT;
                cnt_d   = WAIT_INIT;
            end
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (cnt_q != 2'd0) cnt_d   = cnt_q - 2'd1;
                    else               state_d = ST_IDLE;
                end
                ST_ERR1: state_d = ST_ERR2;
                ST_ERR2: state_d = ST_IDLE;
                default: ;
            endcase
        end
    end

    // A read accepted while a write to the same word completes sees the new lanes.
    always_comb begin
        rd_merged = mem[ap_word];
        for (int i = 0; i < 4; i++) begin
            if (wr_en && dp_be_q[i] && dp_word_q == ap_word)
                rd_merged[8*i +: 8] = HWDATA[8*i +: 8];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            dp_active_q <= 1'b0;
            dp_write_q  <= 1'b0;
            dp_word_q   <= '0;
            dp_be_q     <= 4'b0000;
            HRDATA      <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take) begin
                dp_active_q <= legal;
                dp_write_q  <= HWRITE;
                dp_word_q   <= ap_word;
                dp_be_q     <= byte_en(HSIZE, HADDR[1:0]);
            end else if (HREADYOUT) begin
                dp_active_q <= 1'b0;
            end

            // Zero-wait reads load at acceptance; otherwise on entering the ready cycle.
            if (WAIT_STATES == 0) begin
                if (take && legal && !HWRITE) HRDATA <= rd_merged;
            end else if (state_q == ST_WAIT && cnt_q == 2'd1 && !dp_write_q) begin
                HRDATA <= mem[dp_word_q];
            end
        end
    end

    // NOTE: the storage array has no reset; contents survive rst_i, and a cut
    // data phase cannot write because dp_active_q is cleared asynchronously.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (dp_be_q[i]) mem[dp_word_q][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_kamikaze_ahb_ram.sv
// Self-checking bench: two RAM instances (0 and 2 wait states) driven by an
// AHB master model and compared against a sequential-memory reference.
module tb_kamikaze_ahb_ram;

    localparam int AW     = 12;
    localparam int NWORDS = 16;

    typedef struct {
        bit          trans;
        bit          busy;
        bit          write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        hsel0, hsel2;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] rdata0, rdata2;
    logic        ready0, ready2, resp0, resp2;

    int checks   = 0;
    int failures = 0;

    xfer_t       q[$];
    logic [31:0] mdl [2][NWORDS];
    logic [31:0] last_rd [2];
    logic [31:0] last_obs [2];

    always #5 clk_i = ~clk_i;

    kamikaze_ahb_ram #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .HSEL(hsel0), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'b000), .HPROT(4'b0011),
        .HMASTLOCK(1'b0), .HWDATA(HWDATA), .HREADYIN(ready0), .HRDATA(rdata0),
        .HREADYOUT(ready0), .HRESP(resp0)
    );

    kamikaze_ahb_ram #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .HSEL(hsel2), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'b001), .HPROT(4'b0011),
        .HMASTLOCK(1'b0), .HWDATA(HWDATA), .HREADYIN(ready2), .HRDATA(rdata2),
        .HREADYOUT(ready2), .HRESP(resp2)
    );

    function automatic xfer_t mk(bit wr, logic [31:0] a, logic [2:0] s, logic [31:0] d);
        xfer_t x;
        x.trans = 1'b1; x.busy = 1'b0; x.write = wr;
        x.addr = a; x.size = s; x.wdata = d;
        return x;
    endfunction

    function automatic bit is_legal(xfer_t x);
        if (x.size > 3'd2) return 1'b0;
        if (x.size == 3'd1 && x.addr % 2 != 0) return 1'b0;
        if (x.size == 3'd2 && x.addr % 4 != 0) return 1'b0;
        return longint'(x.addr) < 4 * (longint'(1) << AW);
    endfunction

    function automatic void model_write(int w, xfer_t x);
        int nbytes = 1 << x.size;
        int base   = int'(x.addr % 4);
        int word   = int'(x.addr / 4);
        for (int b = 0; b < nbytes; b++)
            mdl[w][word][8*(base+b) +: 8] = x.wdata[8*(base+b) +: 8];
    endfunction

    function automatic xfer_t rand_xfer();
        xfer_t x;
        int k = $urandom_range(0, 19);
        x.trans = (k >= 3);
        x.busy  = (k == 1);
        x.write = 1'($urandom_range(0, 1));
        x.size  = (k == 19) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        x.addr  = (k == 18) ? 32'h4000 + 32'($urandom_range(0, 255)) * 4
                            : 32'($urandom_range(0, 4*NWORDS - 1));
        if ($urandom_range(0, 3) != 0) x.addr &= ~((32'd1 << x.size) - 32'd1);
        x.wdata = $urandom;
        return x;
    endfunction

    task automatic drive_ap(input int w, input bit on, input xfer_t x);
        hsel0  = on && (w == 0);
        hsel2  = on && (w == 1);
        HTRANS = !on ? 2'b00 : (x.trans ? 2'b10 : (x.busy ? 2'b01 : 2'b00));
        HWRITE = on && x.write;
        HADDR  = on ? x.addr : 32'd0;
        HSIZE  = on ? x.size : 3'd0;
    endtask

    // Plays the queue as an AHB master: an address is held until HREADY is high.
    task automatic run_seq(input int w);
        xfer_t       ap, dp;
        bit          ap_on = 0, dp_on = 0, r_prev = 1, r, resp, lg;
        logic [31:0] rd, exp;
        int          low = 0, ws, guard = 0;
        ws = (w == 0) ? 0 : 2;
        forever begin
            @(negedge clk_i);
            if (r_prev) begin
                dp_on = ap_on && ap.trans;
                dp    = ap;
                low   = 0;
                if (q.size() > 0) begin ap = q.pop_front(); ap_on = 1; end
                else ap_on = 0;
                drive_ap(w, ap_on, ap);
                HWDATA = dp_on ? dp.wdata : 32'd0;
            end
            r    = (w == 0) ? ready0 : ready2;
            resp = (w == 0) ? resp0  : resp2;
            rd   = (w == 0) ? rdata0 : rdata2;
            if (dp_on) begin
                lg = is_legal(dp);
                if (!r) begin
                    low++;
                    checks++;
                    if (resp !== !lg) begin failures++; $display("FAIL resp_wait dut=%0d got=%b exp=%b", w, resp, !lg); end
                    checks++;
                    if (rd !== last_rd[w]) begin failures++; $display("FAIL hold_wait dut=%0d got=%h exp=%h", w, rd, last_rd[w]); end
                end else begin
                    checks++;
                    if (low != (lg ? ws : 1)) begin failures++; $display("FAIL wait_count dut=%0d addr=%h got=%0d exp=%0d", w, dp.addr, low, lg ? ws : 1); end
                    checks++;
                    if (resp !== !lg) begin failures++; $display("FAIL resp dut=%0d addr=%h got=%b exp=%b", w, dp.addr, resp, !lg); end
                    if (lg && dp.write) model_write(w, dp);
                    if (lg && !dp.write) begin
                        exp = mdl[w][dp.addr / 4];
                        checks++;
                        if (rd !== exp) begin failures++; $display("FAIL rdata dut=%0d addr=%h got=%h exp=%h", w, dp.addr, rd, exp); end
                        last_rd[w]  = exp;
                        last_obs[w] = rd;
                    end else begin
                        checks++;
                        if (rd !== last_rd[w]) begin failures++; $display("FAIL hold dut=%0d got=%h exp=%h", w, rd, last_rd[w]); end
                    end
                end
            end else begin
                checks++;
                if (r !== 1'b1 || resp !== 1'b0 || rd !== last_rd[w]) begin
                    failures++;
                    $display("FAIL idle_phase dut=%0d got=%b/%b/%h exp=1/0/%h", w, r, resp, rd, last_rd[w]);
                end
            end
            r_prev = r;
            if (r && !ap_on) break;
            guard++;
            if (guard > 4000) begin
                failures++;
                $display("FAIL timeout dut=%0d got=%0d cycles exp=<4000", w, guard);
                drive_ap(w, 0, ap);
                q.delete();
                break;
            end
        end
    endtask

    task automatic test_reset();
        xfer_t none;
        none = mk(0, 0, 0, 0);
        drive_ap(0, 0, none);
        HWDATA = 32'd0;
        rst_i  = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++; if (ready0 !== 1'b1) begin failures++; $display("FAIL rst_ready0 got=%b exp=1", ready0); end
        checks++; if (resp0  !== 1'b0) begin failures++; $display("FAIL rst_resp0 got=%b exp=0", resp0); end
        checks++; if (rdata0 !== 32'd0) begin failures++; $display("FAIL rst_rdata0 got=%h exp=0", rdata0); end
        checks++; if (ready2 !== 1'b1) begin failures++; $display("FAIL rst_ready2 got=%b exp=1", ready2); end
        checks++; if (resp2  !== 1'b0) begin failures++; $display("FAIL rst_resp2 got=%b exp=0", resp2); end
        checks++; if (rdata2 !== 32'd0) begin failures++; $display("FAIL rst_rdata2 got=%h exp=0", rdata2); end
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        rst_i = 1'b1;
    endtask

    task automatic preload(input int w);
        for (int i = 0; i < NWORDS; i++) q.push_back(mk(1, 32'(i * 4), 3'd2, $urandom));
        run_seq(w);
    endtask

    task automatic test_zero_wait();
        q.push_back(mk(1, 32'h10, 3'd2, 32'hDEADBEEF));
        q.push_back(mk(0, 32'h10, 3'd2, 32'd0));
        run_seq(0);
        checks++;
        if (last_obs[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_after_wr got=%h exp=deadbeef", last_obs[0]); end

        q.push_back(mk(1, 32'h10, 3'd2, 32'h11223344));
        q.push_back(mk(1, 32'h11, 3'd0, 32'h0000AA00));
        q.push_back(mk(0, 32'h10, 3'd2, 32'd0));
        run_seq(0);
        checks++;
        if (last_obs[0] !== 32'h1122AA44) begin failures++; $display("FAIL byte_forward got=%h exp=1122aa44", last_obs[0]); end
    endtask

    task automatic test_wait_states();
        q.push_back(mk(1, 32'h0, 3'd2, 32'hCAFEF00D));
        q.push_back(mk(0, 32'h0, 3'd2, 32'd0));
        run_seq(1);
        checks++;
        if (last_obs[1] !== 32'hCAFEF00D) begin failures++; $display("FAIL wait_read got=%h exp=cafef00d", last_obs[1]); end
    endtask

    task automatic test_errors();
        for (int w = 0; w < 2; w++) begin
            q.push_back(mk(0, 32'h2,    3'd2, 32'd0));
            q.push_back(mk(0, 32'h4000, 3'd2, 32'd0));
            q.push_back(mk(1, 32'h2,    3'd2, 32'hBAD0BAD0));
            q.push_back(mk(1, 32'h3,    3'd1, 32'hBAD1BAD1));
            q.push_back(mk(1, 32'h0,    3'd3, 32'hBAD2BAD2));
            q.push_back(mk(1, 32'h4004, 3'd2, 32'hBAD3BAD3));
            q.push_back(mk(0, 32'h0,    3'd2, 32'd0));
            run_seq(w);
        end
    endtask

    task automatic test_back_to_back();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 200; i++) q.push_back(rand_xfer());
            run_seq(w);
        end
    endtask

    task automatic test_reset_mid_wait();
        xfer_t       wr;
        logic [31:0] old;
        wr  = mk(1, 32'h20, 3'd2, 32'h5A5A5A5A);
        old = mdl[1][8];
        @(negedge clk_i);
        drive_ap(1, 1, wr);
        HWDATA = 32'd0;
        @(negedge clk_i);
        drive_ap(1, 0, wr);
        HWDATA = wr.wdata;
        checks++;
        if (ready2 !== 1'b0) begin failures++; $display("FAIL mid_wait_ready got=%b exp=0", ready2); end
        rst_i = 1'b0;
        #1;
        checks++; if (ready2 !== 1'b1) begin failures++; $display("FAIL rst_cut_ready got=%b exp=1", ready2); end
        checks++; if (resp2  !== 1'b0) begin failures++; $display("FAIL rst_cut_resp got=%b exp=0", resp2); end
        checks++; if (rdata2 !== 32'd0) begin failures++; $display("FAIL rst_cut_rdata got=%h exp=0", rdata2); end
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        @(negedge clk_i);
        rst_i = 1'b1;
        q.push_back(mk(0, 32'h20, 3'd2, 32'd0));
        run_seq(1);
        checks++;
        if (last_obs[1] !== old) begin failures++; $display("FAIL cut_write got=%h exp=%h", last_obs[1], old); end
    endtask

    initial begin
        test_reset();
        preload(0);
        preload(1);
        test_zero_wait();
        test_wait_states();
        test_errors();
        test_back_to_back();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
